// File: rtl/ahb_mem_slave.sv
// AHB-Lite subordinate backed by a word-organised SRAM with configurable wait states and two-cycle ERROR responses.
// Optional macro AHB_MEM_WPROT_EN makes the upper half of the word space read-only.
module ahb_mem_slave #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [2:0] WS_LAST = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;

  state_t            state, state_nxt;
  logic [2:0]        cnt, cnt_nxt;
  logic [ADDR_W-1:0] cap_idx;
  logic [1:0]        cap_lane;
  logic [2:0]        cap_size;
  logic              cap_wr;
  logic [3:0]        be;
  logic              slave_rdy, accept, illegal, wprot_hit;
  logic              unused_trans;
  logic [31:0]       mem [DEPTH];

  assign unused_trans = HTRANS[0];

  assign slave_rdy = (state != ST_WAIT) && (state != ST_ERR1);
  assign HREADYOUT = slave_rdy;
  assign accept    = HSEL && HTRANS[1] && HREADY && slave_rdy;

`ifdef AHB_MEM_WPROT_EN
  assign wprot_hit = HWRITE && HADDR[ADDR_W+1];
`else
  assign wprot_hit = 1'b0;
`endif

  assign illegal = (|HADDR[31:ADDR_W+2]) || (HSIZE > 3'b010) ||
                   ((HSIZE == 3'b001) && HADDR[0]) ||
                   ((HSIZE == 3'b010) && (|HADDR[1:0])) || wprot_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= 3'd0;
      cap_idx  <= '0;
      cap_lane <= 2'd0;
      cap_size <= 3'd0;
      cap_wr   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        cap_idx  <= HADDR[ADDR_W+1:2];
        cap_lane <= HADDR[1:0];
        cap_size <= HSIZE;
        cap_wr   <= HWRITE;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    HRESP     = 1'b0;
    HRDATA    = 32'd0;
    case (state)
      ST_IDLE: state_nxt = ST_IDLE;
      ST_WAIT: begin
        if (cnt == WS_LAST) begin
          state_nxt = ST_DATA;
          cnt_nxt   = 3'd0;
        end else begin
          cnt_nxt = cnt + 3'd1;
        end
      end
      ST_DATA: begin
        if (!cap_wr) HRDATA = mem[cap_idx];
        state_nxt = ST_IDLE;
      end
      ST_ERR1: begin
        HRESP     = 1'b1;
        state_nxt = ST_ERR2;
      end
      ST_ERR2: begin
        HRESP     = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // accept is only possible in IDLE/DATA/ERR2, so this overrides their IDLE default
    if (accept) begin
      cnt_nxt = 3'd0;
      if (illegal)               state_nxt = ST_ERR1;
      else if (WAIT_STATES == 0) state_nxt = ST_DATA;
      else                       state_nxt = ST_WAIT;
    end
  end

  always_comb begin
    case (cap_size)
      3'b000:  be = 4'b0001 << cap_lane;
      3'b001:  be = cap_lane[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // Write commits at the posedge closing the DATA cycle; a reset on that edge abandons it.
  always_ff @(posedge clk) begin
    if (!rst && (state == ST_DATA) && cap_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[cap_idx][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Randomized bench for ahb_mem_slave: two instances (0 and 3 wait states) checked cycle by cycle against a transaction model.
module tb_ahb_mem_slave;
  localparam int AW    = 8;
  localparam int DEPTH = 1 << AW;
`ifdef AHB_MEM_WPROT_EN
  localparam bit WPROT = 1'b1;
`else
  localparam bit WPROT = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [3:0]  gap;
  } tx_t;

  typedef struct packed {
    logic rdy;
    logic resp;
    logic fin_rd;
    logic fin_wr;
    tx_t  t;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        hsel, hwrite;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [31:0] rdata0, rdata3, bus_rdata;
  logic        rdy0, rdy3, resp0, resp3, bus_rdy, bus_resp;

  int checks   = 0;
  int failures = 0;

  tx_t  txq[$];
  exp_t expq[$];
  logic [31:0] mm [2][DEPTH];
  logic [3:0]  mv [2][DEPTH];

  always #5 clk = ~clk;

  assign bus_rdy   = sel ? rdy3   : rdy0;
  assign bus_resp  = sel ? resp3  : resp0;
  assign bus_rdata = sel ? rdata3 : rdata0;

  ahb_mem_slave #(.ADDR_W(AW), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst), .HSEL(hsel & ~sel), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(bus_rdy),
    .HRDATA(rdata0), .HREADYOUT(rdy0), .HRESP(resp0)
  );

  ahb_mem_slave #(.ADDR_W(AW), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .rst(rst), .HSEL(hsel & sel), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(bus_rdy),
    .HRDATA(rdata3), .HREADYOUT(rdy3), .HRESP(resp3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_legal(input tx_t t);
    if (t.addr >= 32'(4 * DEPTH)) return 1'b0;
    if (t.size > 3'd2) return 1'b0;
    if ((t.addr % (32'd1 << t.size)) != 0) return 1'b0;
    if (WPROT && t.wr && (t.addr >= 32'(2 * DEPTH))) return 1'b0;
    return 1'b1;
  endfunction

  function automatic tx_t mk(input logic [31:0] a, input logic w, input logic [2:0] s,
                             input logic [31:0] d);
    tx_t t;
    t.addr = a; t.wr = w; t.size = s; t.wdata = d; t.gap = 4'd0;
    return t;
  endfunction

  function automatic tx_t rnd_tx();
    tx_t t;
    int r;
    logic [31:0] w, off;
    r = $urandom_range(0, 9);
    w = ($urandom_range(0, 2) == 0) ? 32'(128 + $urandom_range(0, 3)) : 32'($urandom_range(0, 7));
    t.size = 3'($urandom_range(0, 2));
    off = 32'($urandom_range(0, 3));
    if (r != 0) off = (off >> t.size) << t.size;
    t.addr = w * 4 + off;
    if (r == 1) t.size = 3'($urandom_range(3, 7));
    if (r == 2) t.addr = $urandom | 32'h400;
    t.wr    = 1'($urandom_range(0, 1));
    t.wdata = $urandom;
    t.gap   = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 2)) : 4'd0;
    return t;
  endfunction

  task automatic model_write(input int d, input tx_t t);
    int w, lane;
    w = int'(t.addr[AW+1:2]);
    for (int b = 0; b < (1 << t.size); b++) begin
      lane = int'(t.addr[1:0]) + b;
      mm[d][w][lane*8 +: 8] = t.wdata[lane*8 +: 8];
      mv[d][w][lane] = 1'b1;
    end
  endtask

  task automatic drive_idle();
    case ($urandom_range(0, 2))
      0: begin hsel = 1'b0; htrans = 2'b10; end
      1: begin hsel = 1'b1; htrans = 2'b00; end
      default: begin hsel = 1'b1; htrans = 2'b01; end
    endcase
    haddr  = $urandom;
    hwrite = 1'($urandom_range(0, 1));
    hsize  = 3'($urandom_range(0, 2));
  endtask

  // Drains txq through instance d (0: no wait states, 1: three), checking every cycle.
  task automatic run(input int d);
    tx_t  t;
    exp_t e;
    logic [31:0] nxt_wd, mask, wd;
    bit   load_wd;
    int   guard, ws;
    ws = (d == 1) ? 3 : 0;
    load_wd = 1'b0;
    nxt_wd = 32'd0;
    guard = 0;
    while ((txq.size() > 0 || expq.size() > 0) && guard < 5000) begin
      @(negedge clk);
      guard++;
      if (load_wd) begin hwdata = nxt_wd; load_wd = 1'b0; end
      if (expq.size() > 0) e = expq.pop_front();
      else e = '{rdy: 1'b1, resp: 1'b0, fin_rd: 1'b0, fin_wr: 1'b0, t: '0};
      chk("hreadyout", 32'(bus_rdy), 32'(e.rdy));
      chk("hresp", 32'(bus_resp), 32'(e.resp));
      if (e.fin_rd) begin
        wd = mm[d][e.t.addr[AW+1:2]];
        mask = {{8{mv[d][e.t.addr[AW+1:2]][3]}}, {8{mv[d][e.t.addr[AW+1:2]][2]}},
                {8{mv[d][e.t.addr[AW+1:2]][1]}}, {8{mv[d][e.t.addr[AW+1:2]][0]}}};
        if (mask != 0) chk("hrdata", bus_rdata & mask, wd & mask);
      end else begin
        chk("hrdata_idle", bus_rdata, 32'd0);
      end
      if (e.fin_wr) model_write(d, e.t);
      if (!e.rdy) begin
        // master-side noise during stalls must be ignored
        hsel = 1'b1; htrans = 2'b10; haddr = $urandom; hwrite = 1'($urandom_range(0, 1));
      end else if (txq.size() > 0 && txq[0].gap != 0) begin
        t = txq[0]; t.gap = t.gap - 4'd1; txq[0] = t;
        drive_idle();
      end else if (txq.size() > 0) begin
        t = txq.pop_front();
        hsel = 1'b1; htrans = {1'b1, 1'($urandom_range(0, 1))};
        haddr = t.addr; hwrite = t.wr; hsize = t.size;
        if (t.wr) begin nxt_wd = t.wdata; load_wd = 1'b1; end
        if (is_legal(t)) begin
          for (int i = 0; i < ws; i++) expq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, t});
          expq.push_back('{1'b1, 1'b0, !t.wr, t.wr, t});
        end else begin
          expq.push_back('{1'b0, 1'b1, 1'b0, 1'b0, t});
          expq.push_back('{1'b1, 1'b1, 1'b0, 1'b0, t});
        end
      end else begin
        drive_idle();
      end
    end
    if (guard >= 5000) chk("run_timeout", 32'(guard), 32'd0);
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; hsel = 1'b0; htrans = 2'b00; haddr = 32'd0;
    hwrite = 1'b0; hsize = 3'd0; hwdata = 32'd0;
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < DEPTH; w++) begin mm[d][w] = 32'd0; mv[d][w] = 4'd0; end
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      chk("rst_hreadyout", 32'(bus_rdy), 32'd1);
      chk("rst_hresp", 32'(bus_resp), 32'd0);
      chk("rst_hrdata", bus_rdata, 32'd0);
    end
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // zero-wait instance: directed then random
    txq.push_back(mk(32'h00, 1'b1, 3'd2, 32'h00C0FFEE));
    txq.push_back(mk(32'h10, 1'b1, 3'd2, 32'hDEADBEEF));
    txq.push_back(mk(32'h10, 1'b0, 3'd2, 32'h0));
    txq.push_back(mk(32'h11, 1'b1, 3'd0, 32'h0000AA00));
    txq.push_back(mk(32'h10, 1'b0, 3'd2, 32'h0));
    txq.push_back(mk(32'h02, 1'b0, 3'd2, 32'h0));
    txq.push_back(mk(32'h400, 1'b1, 3'd2, 32'h11111111));
    txq.push_back(mk(32'h00, 1'b0, 3'd2, 32'h0));
    txq.push_back(mk(32'h200, 1'b1, 3'd2, 32'h12345678));
    txq.push_back(mk(32'h200, 1'b0, 3'd2, 32'h0));
    txq.push_back(mk(32'h12, 1'b1, 3'd1, 32'h55660000));
    txq.push_back(mk(32'h13, 1'b1, 3'd1, 32'hFFFFFFFF));
    txq.push_back(mk(32'h10, 1'b1, 3'd3, 32'hFFFFFFFF));
    txq.push_back(mk(32'h10, 1'b0, 3'd2, 32'h0));
    for (int i = 0; i < 150; i++) txq.push_back(rnd_tx());
    run(0);

    // three-wait instance
    sel = 1'b1;
    txq.push_back(mk(32'h30, 1'b1, 3'd2, 32'hCAFE0030));
    txq.push_back(mk(32'h20, 1'b1, 3'd2, 32'h20202020));
    txq.push_back(mk(32'h20, 1'b0, 3'd2, 32'h0));
    txq.push_back(mk(32'h02, 1'b0, 3'd2, 32'h0));
    for (int i = 0; i < 100; i++) txq.push_back(rnd_tx());
    run(1);

    // reset during the wait phase of a write to 0x30
    @(negedge clk);
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h30; hwrite = 1'b1; hsize = 3'd2;
    @(negedge clk);
    hwdata = 32'h0BAD0BAD; hsel = 1'b0; htrans = 2'b00;
    chk("wait_before_rst", 32'(bus_rdy), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_hreadyout", 32'(bus_rdy), 32'd1);
    chk("post_rst_hresp", 32'(bus_resp), 32'd0);
    chk("post_rst_hrdata", bus_rdata, 32'd0);
    rst = 1'b0;
    txq.push_back(mk(32'h30, 1'b0, 3'd2, 32'h0));
    run(1);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
